// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: opcodes, FSM states,
// ALU operation classes, datapath mux selects and the packed control word.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_ALU_WB   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JAL      = 4'd11,
    ST_LUI      = 4'd12,
    ST_TRAP     = 4'd13
  } state_e;

  localparam logic [2:0] ALU_OP_R   = 3'b000;
  localparam logic [2:0] ALU_OP_I   = 3'b001;
  localparam logic [2:0] ALU_OP_U   = 3'b010;
  localparam logic [2:0] ALU_OP_B   = 3'b011;
  localparam logic [2:0] ALU_OP_ADD = 3'b100;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_word_t;

  // Opcode dispatch out of DECODE; anything unsupported lands in TRAP.
  function automatic state_e decode_opcode(input logic [6:0] op);
    case (op)
      OPC_R:                decode_opcode = ST_EXEC_R;
      OPC_I:                decode_opcode = ST_EXEC_I;
      OPC_LOAD, OPC_STORE:  decode_opcode = ST_MEM_ADDR;
      OPC_LUI:              decode_opcode = ST_LUI;
      OPC_BRANCH:           decode_opcode = ST_BRANCH;
      OPC_JAL:              decode_opcode = ST_JAL;
      default:              decode_opcode = ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, control strobes out.
// Handshake: Mem_Ready_i high in a cycle where a memory strobe is asserted completes that access.
interface multicycle_control_if;
  logic [6:0] OP_i;
  logic       Mem_Ready_i;
  logic       PC_Write_o;
  logic       PC_Write_Cond_o;
  logic       PC_Src_o;
  logic       IorD_o;
  logic       Mem_Read_o;
  logic       Mem_Write_o;
  logic       IR_Write_o;
  logic       Mem_to_Reg_o;
  logic       Reg_Write_o;
  logic [1:0] ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic       Illegal_o;
  logic [3:0] State_o;

  modport master (
    input  OP_i, Mem_Ready_i,
    output PC_Write_o, PC_Write_Cond_o, PC_Src_o, IorD_o, Mem_Read_o, Mem_Write_o,
           IR_Write_o, Mem_to_Reg_o, Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o,
           ALU_Op_o, Illegal_o, State_o
  );

  modport slave (
    output OP_i, Mem_Ready_i,
    input  PC_Write_o, PC_Write_Cond_o, PC_Src_o, IorD_o, Mem_Read_o, Mem_Write_o,
           IR_Write_o, Mem_to_Reg_o, Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o,
           ALU_Op_o, Illegal_o, State_o
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Moore output decode: current state (plus Mem_Ready_i in FETCH) -> control word.
module ctrl_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_mem_ready,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.iord      = IORD_PC;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_a = SRC_A_PC;
        o_ctrl.alu_src_b = SRC_B_FOUR;
        o_ctrl.alu_op    = ALU_OP_ADD;
        // IR and PC only commit on the cycle the instruction word arrives.
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_a = SRC_A_OLDPC;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_EXEC_R: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_RS2;
        o_ctrl.alu_op    = ALU_OP_R;
      end
      ST_EXEC_I: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_I;
      end
      ST_LUI: begin
        o_ctrl.alu_src_a = SRC_A_ZERO;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_U;
      end
      ST_ALU_WB: o_ctrl.reg_write = 1'b1;
      ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_RD: begin
        o_ctrl.iord     = IORD_ALUOUT;
        o_ctrl.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.iord      = IORD_ALUOUT;
        o_ctrl.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = SRC_A_RS1;
        o_ctrl.alu_src_b     = SRC_B_RS2;
        o_ctrl.alu_op        = ALU_OP_B;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = 1'b1;
      end
      ST_JAL: begin
        o_ctrl.alu_src_a = SRC_A_OLDPC;
        o_ctrl.alu_src_b = SRC_B_FOUR;
        o_ctrl.alu_op    = ALU_OP_ADD;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_src    = 1'b1;
      end
      ST_TRAP: o_ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: state register and next-state logic; the control word
// comes from ctrl_output_decode.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e     r_state;
  state_e     w_next_state;
  logic       r_is_store;
  logic       w_is_store_next;
  ctrl_word_t w_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_is_store <= w_is_store_next;
    end
  end

  // OP_i is only looked at in DECODE; MEM_ADDR uses the captured load/store flag.
  always_comb begin
    w_next_state    = r_state;
    w_is_store_next = r_is_store;
    case (r_state)
      ST_IDLE:   w_next_state = ST_FETCH;
      ST_FETCH:  if (bus.Mem_Ready_i) w_next_state = ST_DECODE;
      ST_DECODE: begin
        w_next_state    = decode_opcode(bus.OP_i);
        w_is_store_next = (bus.OP_i == OPC_STORE);
      end
      ST_EXEC_R, ST_EXEC_I, ST_LUI:            w_next_state = ST_ALU_WB;
      ST_MEM_ADDR: w_next_state = r_is_store ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: if (bus.Mem_Ready_i) w_next_state = ST_MEM_WB;
      ST_MEM_WR: if (bus.Mem_Ready_i) w_next_state = ST_FETCH;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL: w_next_state = ST_FETCH;
      ST_TRAP:   w_next_state = ST_TRAP;
      default:   w_next_state = ST_TRAP;
    endcase
  end

  ctrl_output_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (bus.Mem_Ready_i),
    .o_ctrl      (w_ctrl)
  );

  assign bus.PC_Write_o      = w_ctrl.pc_write;
  assign bus.PC_Write_Cond_o = w_ctrl.pc_write_cond;
  assign bus.PC_Src_o        = w_ctrl.pc_src;
  assign bus.IorD_o          = w_ctrl.iord;
  assign bus.Mem_Read_o      = w_ctrl.mem_read;
  assign bus.Mem_Write_o     = w_ctrl.mem_write;
  assign bus.IR_Write_o      = w_ctrl.ir_write;
  assign bus.Mem_to_Reg_o    = w_ctrl.mem_to_reg;
  assign bus.Reg_Write_o     = w_ctrl.reg_write;
  assign bus.ALU_Src_A_o     = w_ctrl.alu_src_a;
  assign bus.ALU_Src_B_o     = w_ctrl.alu_src_b;
  assign bus.ALU_Op_o        = w_ctrl.alu_op;
  assign bus.Illegal_o       = w_ctrl.illegal;
  assign bus.State_o         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle sequences go into a
// scoreboard queue; a negedge monitor pops one expectation per cycle.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  localparam int W = 21;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic        mon_on = 1'b0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] mon_exp;
  string        mon_tag;
  logic [W-1:0] act_w;

  assign act_w = {bus.State_o, bus.PC_Write_o, bus.PC_Write_Cond_o, bus.PC_Src_o,
                  bus.IorD_o, bus.Mem_Read_o, bus.Mem_Write_o, bus.IR_Write_o,
                  bus.Mem_to_Reg_o, bus.Reg_Write_o, bus.ALU_Src_A_o,
                  bus.ALU_Src_B_o, bus.ALU_Op_o, bus.Illegal_o};

  typedef struct {
    logic [W-1:0] w;
    logic         rdy;
    logic         dec;
  } cyc_t;

  logic [6:0] legal_ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h63, 7'h6F};

  // strobes = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write}
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [8:0] strobes,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] op, input logic ill);
    return {st, strobes, a, b, op, ill};
  endfunction

  function automatic cyc_t fc(input logic [W-1:0] w);
    cyc_t c;
    c.w   = w;
    c.rdy = 1'($urandom);
    c.dec = 1'b0;
    return c;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow cycle %0d actual %h", cyc, act_w);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (act_w !== mon_exp) begin
          errors++;
          $display("FAIL %s cycle %0d actual %h expected %h", mon_tag, cyc, act_w, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [W-1:0] w, input string t);
    exp_q.push_back(w);
    tag_q.push_back(t);
  endtask

  task automatic idle_cycle(input string t);
    bus.OP_i        = 7'($urandom);
    bus.Mem_Ready_i = 1'($urandom);
    push_exp(mk(ST_IDLE, 9'b0, 2'b00, 2'b00, 3'b000, 1'b0), t);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) idle_cycle("reset_held");
    reset = 1'b1;
    idle_cycle("reset_release");
  endtask

  // One instruction: wf fetch wait cycles, wm memory wait cycles, ntrap TRAP cycles
  // to observe, and an optional cycle index at which reset is asserted mid-cycle.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm,
                           input int ntrap, input int abort_at);
    cyc_t s[$];
    cyc_t c;
    logic r;
    for (int i = 0; i <= wf; i++) begin
      r     = (i == wf);
      c.w   = mk(ST_FETCH, {r, 3'b000, 1'b1, 1'b0, r, 2'b00}, 2'b00, 2'b01, 3'b100, 1'b0);
      c.rdy = r;
      c.dec = 1'b0;
      s.push_back(c);
    end
    c     = fc(mk(ST_DECODE, 9'b0, 2'b01, 2'b10, 3'b100, 1'b0));
    c.dec = 1'b1;
    s.push_back(c);
    case (op)
      OPC_R: begin
        s.push_back(fc(mk(ST_EXEC_R, 9'b0, 2'b10, 2'b00, 3'b000, 1'b0)));
        s.push_back(fc(mk(ST_ALU_WB, 9'b000_000_001, 2'b00, 2'b00, 3'b000, 1'b0)));
      end
      OPC_I: begin
        s.push_back(fc(mk(ST_EXEC_I, 9'b0, 2'b10, 2'b10, 3'b001, 1'b0)));
        s.push_back(fc(mk(ST_ALU_WB, 9'b000_000_001, 2'b00, 2'b00, 3'b000, 1'b0)));
      end
      OPC_LUI: begin
        s.push_back(fc(mk(ST_LUI, 9'b0, 2'b11, 2'b10, 3'b010, 1'b0)));
        s.push_back(fc(mk(ST_ALU_WB, 9'b000_000_001, 2'b00, 2'b00, 3'b000, 1'b0)));
      end
      OPC_LOAD, OPC_STORE: begin
        s.push_back(fc(mk(ST_MEM_ADDR, 9'b0, 2'b10, 2'b10, 3'b100, 1'b0)));
        for (int i = 0; i <= wm; i++) begin
          c.rdy = (i == wm);
          c.dec = 1'b0;
          if (op == OPC_LOAD)
            c.w = mk(ST_MEM_RD, 9'b000_110_000, 2'b00, 2'b00, 3'b000, 1'b0);
          else
            c.w = mk(ST_MEM_WR, 9'b000_101_000, 2'b00, 2'b00, 3'b000, 1'b0);
          s.push_back(c);
        end
        if (op == OPC_LOAD)
          s.push_back(fc(mk(ST_MEM_WB, 9'b000_000_011, 2'b00, 2'b00, 3'b000, 1'b0)));
      end
      OPC_BRANCH: s.push_back(fc(mk(ST_BRANCH, 9'b011_000_000, 2'b10, 2'b00, 3'b011, 1'b0)));
      OPC_JAL:    s.push_back(fc(mk(ST_JAL, 9'b101_000_001, 2'b01, 2'b01, 3'b100, 1'b0)));
      default:    repeat (ntrap) s.push_back(fc(mk(ST_TRAP, 9'b0, 2'b00, 2'b00, 3'b000, 1'b1)));
    endcase

    foreach (s[k]) begin
      bus.OP_i        = s[k].dec ? op : 7'($urandom);
      bus.Mem_Ready_i = s[k].rdy;
      if (k == abort_at) begin
        push_exp(mk(ST_IDLE, 9'b0, 2'b00, 2'b00, 3'b000, 1'b0), "abort_reset");
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.Mem_Write_o !== 1'b0 || bus.State_o !== ST_IDLE) begin
          errors++;
          $display("FAIL abort_async mem_write %b state %0d expected 0 and %0d",
                   bus.Mem_Write_o, bus.State_o, ST_IDLE);
        end
        @(posedge clk); #1;
        return;
      end
      push_exp(s[k].w, $sformatf("op%02h_c%0d", op, k));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.OP_i        = 7'h00;
    bus.Mem_Ready_i = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    do_reset(2);

    run_instr(OPC_R, 0, 0, 0, -1);
    run_instr(OPC_LOAD, 0, 3, 0, -1);
    run_instr(OPC_BRANCH, 0, 0, 0, -1);
    run_instr(OPC_JAL, 0, 0, 0, -1);
    run_instr(OPC_STORE, 1, 0, 0, -1);
    run_instr(OPC_I, 2, 0, 0, -1);
    run_instr(OPC_LUI, 0, 0, 0, -1);
    run_instr(OPC_STORE, 0, 5, 0, 4);
    do_reset(1);
    run_instr(7'h7F, 0, 0, 100, -1);
    do_reset(1);

    repeat (60) begin
      logic [6:0] op;
      if ($urandom_range(0, 9) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
        run_instr(op, $urandom_range(0, 2), 0, $urandom_range(1, 5), -1);
        do_reset($urandom_range(1, 2));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
        run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
      end
    end

    mon_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain leftover %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
